rv32i_decode_stage: RTL
=======================

// Module: rv32i_decode_stage
// PURPOSE
//  Instruction decode stage: producer side of the ALU control interface. Takes fetched RV32I
//  words with a valid/ready handshake and registers ALUSel_e op, operand selects, immediate,
//  register indices and write-enable for the execute stage. One pipeline register; 1-cycle
//  latency; full throughput; stall and flush support.
// PARAMETERS
//  XLEN          32   datapath width; only 32 supported
//  RESET_PC      0    o_pc value while reset/empty
// PORTS
//  i_clk         in   1     clock; all state on rising edge
//  i_rst_n       in   1     asynchronous, active-low reset
//  i_valid       in   1     upstream instruction valid
//  o_ready       out  1     stage can accept (~o_valid | i_ready)
//  i_instr       in   32    instruction word
//  i_pc          in   32    PC of i_instr
//  i_flush       in   1     kill held and incoming instruction
//  o_valid       out  1     decoded bundle valid
//  i_ready       in   1     execute stage accepts bundle
//  o_pc          out  32    PC of decoded instruction
//  o_alu_op      out  ALUSel_e  op for ALU
//  o_op_a_sel    out  OpASel_e  OPA_RS1 / OPA_PC / OPA_ZERO
//  o_op_b_sel    out  OpBSel_e  OPB_RS2 / OPB_IMM
//  o_imm         out  32    sign-extended immediate
//  o_rs1_addr    out  5     source 1 index (0 when unused)
//  o_rs2_addr    out  5     source 2 index (0 when unused)
//  o_rd_addr     out  5     destination index
//  o_rd_wen      out  1     write-back enable (forced 0 when rd==x0)
//  o_illegal     out  1     unsupported encoding
// BEHAVIOUR
//  - Reset: o_valid=0, o_pc=RESET_PC, o_alu_op=ALU_ADD, all other outputs 0; o_ready=1.
//  - Load when i_valid & o_ready & ~i_flush; o_valid next cycle = 1. i_valid&o_ready&i_flush -> o_valid=0.
//  - Stall: o_valid & ~i_ready -> every output held bit-stable; i_instr ignored.
//  - Bundle consumed (o_valid&i_ready) with no new load -> o_valid=0; payload may hold.
//  - i_flush wins over load and stall: o_valid=0 next edge regardless of i_ready.
//  - Decode: OP: funct3/funct7 -> ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND, A=RS1 B=RS2.
//    OP-IMM: same, B=IMM(I); SLLI/SRLI/SRAI imm = {27'b0,shamt} (funct7 bit stripped, since ALU
//    shifts by full operand_b). LUI: ADD, A=ZERO B=IMM(U). AUIPC: ADD, A=PC B=IMM(U).
//    LOAD/STORE: ADD, A=RS1 B=IMM(I/S); STORE rd_wen=0. BRANCH: BEQ/BNE->SUB, BLT/BGE->SLT,
//    BLTU/BGEU->SLTU, A=RS1 B=RS2, rd_wen=0, imm=B-type. JAL: ADD A=PC B=IMM(J). JALR: ADD A=RS1 B=IMM(I).
//  - Illegal: unknown opcode, bad funct7 on OP/shift-imm, bad funct3 on BRANCH/LOAD/STORE/JALR
//    -> o_illegal=1, o_rd_wen=0, o_alu_op=ALU_ADD, still valid (trap handled downstream).
//  - Immediates: sign bit is instr[31] for all formats; U-type low 12 bits zero; B/J bit0 zero.
// STRUCTURE
//  - rv32i_pkg gains: OpASel_e, OpBSel_e, opcode localparams (OPC_OP, OPC_OP_IMM, OPC_LUI,
//    OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR), funct3/funct7 constants.
//  - Sub-module rv32i_imm_gen: combinational instr+format -> 32-bit imm; rest is one
//    always_comb decoder feeding one always_ff pipeline register.
// TESTING
//  - ADD x3,x1,x2 (0x002081B3), i_ready=1 -> next cycle o_valid=1, ALU_ADD, RS1/RS2, rd=3, wen=1.
//  - SRAI x5,x6,4 (0x40435293) -> ALU_SRA, OPB_IMM, o_imm=0x00000004.
//  - BLTU x1,x2,-8 (0xFE20ECE3) -> ALU_SLTU, OPB_RS2, o_imm=0xFFFFFFF8, o_rd_wen=0.
//  - Hold i_ready=0 4 cycles after LUI x7,0x12345 -> outputs stable, o_ready=0, imm=0x12345000.
//  - i_flush with i_valid=1 and stalled bundle -> o_valid=0 next cycle, no bundle delivered.
//  - Opcode 0x7F, and i_rst_n low mid-stall -> o_illegal=1 wen=0; reset clears o_valid asynchronously.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types: ALU/operand selects, immediate formats, opcode and funct constants.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package rv32i_pkg;

  localparam int RV_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } ALUSel_e;

  typedef enum logic [1:0] {
    OPA_RS1  = 2'd0,
    OPA_PC   = 2'd1,
    OPA_ZERO = 2'd2
  } OpASel_e;

  typedef enum logic {
    OPB_RS2 = 1'b0,
    OPB_IMM = 1'b1
  } OpBSel_e;

  // IMM_SH is the zero-extended shamt of the shift-immediate forms
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_SH   = 3'd2,
    IMM_S    = 3'd3,
    IMM_B    = 3'd4,
    IMM_U    = 3'd5,
    IMM_J    = 3'd6
  } ImmFmt_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;
  localparam logic [2:0] F3_JALR = 3'd0;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  // Register/immediate arithmetic op from funct3; alt selects SUB/SRA
  function automatic ALUSel_e alu_from_f3(input logic [2:0] f3, input logic alt);
    ALUSel_e op;
    op = ALU_ADD;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_decode_stage_if.sv
// Decode-to-execute bundle: decoded ALU control plus valid/ready handshake.
// Latency: n/a (wiring only).
// Backpressure: master holds the bundle while valid & ~ready.
interface rv32i_decode_stage_if;
  import rv32i_pkg::*;

  logic                 valid;
  logic                 ready;
  logic [RV_XLEN-1:0]   pc;
  ALUSel_e              alu_op;
  OpASel_e              op_a_sel;
  OpBSel_e              op_b_sel;
  logic [RV_XLEN-1:0]   imm;
  logic [4:0]           rs1_addr;
  logic [4:0]           rs2_addr;
  logic [4:0]           rd_addr;
  logic                 rd_wen;
  logic                 illegal;

  modport master (
    output valid, pc, alu_op, op_a_sel, op_b_sel, imm,
           rs1_addr, rs2_addr, rd_addr, rd_wen, illegal,
    input  ready
  );

  modport slave (
    input  valid, pc, alu_op, op_a_sel, op_b_sel, imm,
           rs1_addr, rs2_addr, rd_addr, rd_wen, illegal,
    output ready
  );

endinterface

// File: rtl/rv32i_imm_gen.sv
// Immediate generator: selects and sign-extends the immediate field for a given format.
// Latency: combinational.
// Backpressure: none.
module rv32i_imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:7] i_instr,
  input  ImmFmt_e     i_fmt,
  output logic [31:0] o_imm
);

  // Every signed format takes its sign from instr[31]; B/J targets are halfword aligned
  always_comb begin
    o_imm = 32'd0;
    case (i_fmt)
      IMM_I:  o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_SH: o_imm = {27'd0, i_instr[24:20]};
      IMM_S:  o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:  o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                       i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U:  o_imm = {i_instr[31:12], 12'd0};
      IMM_J:  o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                       i_instr[20], i_instr[30:21], 1'b0};
      default: o_imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: decodes one instruction into ALU control and registers it for execute.
// Latency: 1 cycle, full throughput.
// Backpressure: holds the bundle bit-stable while valid & ~ready; flush drops held and incoming.
module rv32i_decode_stage
  import rv32i_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0
)(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [31:0]           i_instr,
  input  logic [31:0]           i_pc,
  input  logic                  i_flush,
  rv32i_decode_stage_if.master  ex_if
);

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  ALUSel_e         w_alu_op;
  OpASel_e         w_op_a_sel;
  OpBSel_e         w_op_b_sel;
  ImmFmt_e         w_fmt;
  logic [31:0]     w_imm;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic            w_writes;
  logic            w_illegal;
  logic            w_rd_wen;
  logic            w_ready;
  logic            w_load;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  ALUSel_e         r_alu_op;
  OpASel_e         r_op_a_sel;
  OpBSel_e         r_op_b_sel;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic            r_rd_wen;
  logic            r_illegal;

  assign w_opc   = i_instr[6:0];
  assign w_f3    = i_instr[14:12];
  assign w_f7    = i_instr[31:25];
  assign w_ready = ~r_valid | ex_if.ready;
  assign w_load  = i_valid & w_ready;
  assign o_ready = w_ready;

  rv32i_imm_gen u_imm_gen (
    .i_instr (i_instr[31:7]),
    .i_fmt   (w_fmt),
    .o_imm   (w_imm)
  );

  // Opcode/funct decode; unused source indices stay 0, illegal encodings fall back to ADD
  always_comb begin
    w_alu_op   = ALU_ADD;
    w_op_a_sel = OPA_RS1;
    w_op_b_sel = OPB_RS2;
    w_fmt      = IMM_NONE;
    w_rs1      = 5'd0;
    w_rs2      = 5'd0;
    w_rd       = 5'd0;
    w_writes   = 1'b0;
    w_illegal  = 1'b0;
    case (w_opc)
      OPC_OP: begin
        w_rs1    = i_instr[19:15];
        w_rs2    = i_instr[24:20];
        w_rd     = i_instr[11:7];
        w_writes = 1'b1;
        if (w_f7 == F7_BASE) begin
          w_alu_op = alu_from_f3(w_f3, 1'b0);
        end else if (w_f7 == F7_ALT && (w_f3 == F3_ADD_SUB || w_f3 == F3_SRL_SRA)) begin
          w_alu_op = alu_from_f3(w_f3, 1'b1);
        end else begin
          w_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        w_rs1      = i_instr[19:15];
        w_rd       = i_instr[11:7];
        w_writes   = 1'b1;
        w_op_b_sel = OPB_IMM;
        w_fmt      = IMM_I;
        w_alu_op   = alu_from_f3(w_f3, 1'b0);
        // Shifts take only shamt: the ALU shifts by the whole operand_b
        if (w_f3 == F3_SLL) begin
          w_fmt     = IMM_SH;
          w_illegal = (w_f7 != F7_BASE);
        end else if (w_f3 == F3_SRL_SRA) begin
          w_fmt     = IMM_SH;
          w_alu_op  = alu_from_f3(w_f3, w_f7 == F7_ALT);
          w_illegal = (w_f7 != F7_BASE) && (w_f7 != F7_ALT);
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        w_rd       = i_instr[11:7];
        w_writes   = 1'b1;
        w_op_a_sel = (w_opc == OPC_LUI) ? OPA_ZERO : OPA_PC;
        w_op_b_sel = OPB_IMM;
        w_fmt      = IMM_U;
      end
      OPC_LOAD: begin
        w_rs1      = i_instr[19:15];
        w_rd       = i_instr[11:7];
        w_writes   = 1'b1;
        w_op_b_sel = OPB_IMM;
        w_fmt      = IMM_I;
        w_illegal  = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
      end
      OPC_STORE: begin
        w_rs1      = i_instr[19:15];
        w_rs2      = i_instr[24:20];
        w_op_b_sel = OPB_IMM;
        w_fmt      = IMM_S;
        w_illegal  = (w_f3 > 3'd2);
      end
      OPC_BRANCH: begin
        w_rs1 = i_instr[19:15];
        w_rs2 = i_instr[24:20];
        w_fmt = IMM_B;
        case (w_f3)
          F3_BEQ, F3_BNE:   w_alu_op = ALU_SUB;
          F3_BLT, F3_BGE:   w_alu_op = ALU_SLT;
          F3_BLTU, F3_BGEU: w_alu_op = ALU_SLTU;
          default:          w_illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        w_rd       = i_instr[11:7];
        w_writes   = 1'b1;
        w_op_a_sel = OPA_PC;
        w_op_b_sel = OPB_IMM;
        w_fmt      = IMM_J;
      end
      OPC_JALR: begin
        w_rs1      = i_instr[19:15];
        w_rd       = i_instr[11:7];
        w_writes   = 1'b1;
        w_op_b_sel = OPB_IMM;
        w_fmt      = IMM_I;
        w_illegal  = (w_f3 != F3_JALR);
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_alu_op = ALU_ADD;
    end
  end

  assign w_rd_wen = w_writes & ~w_illegal & (w_rd != 5'd0);

  // Pipeline register: flush beats load beats consume; a stall leaves everything untouched
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= RESET_PC;
      r_alu_op   <= ALU_ADD;
      r_op_a_sel <= OPA_RS1;
      r_op_b_sel <= OPB_RS2;
      r_imm      <= '0;
      r_rs1      <= 5'd0;
      r_rs2      <= 5'd0;
      r_rd       <= 5'd0;
      r_rd_wen   <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid    <= 1'b1;
      r_pc       <= i_pc;
      r_alu_op   <= w_alu_op;
      r_op_a_sel <= w_op_a_sel;
      r_op_b_sel <= w_op_b_sel;
      r_imm      <= w_imm;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_rd       <= w_rd;
      r_rd_wen   <= w_rd_wen;
      r_illegal  <= w_illegal;
    end else if (ex_if.ready) begin
      r_valid <= 1'b0;
    end
  end

  assign ex_if.valid    = r_valid;
  assign ex_if.pc       = r_pc;
  assign ex_if.alu_op   = r_alu_op;
  assign ex_if.op_a_sel = r_op_a_sel;
  assign ex_if.op_b_sel = r_op_b_sel;
  assign ex_if.imm      = r_imm;
  assign ex_if.rs1_addr = r_rs1;
  assign ex_if.rs2_addr = r_rs2;
  assign ex_if.rd_addr  = r_rd;
  assign ex_if.rd_wen   = r_rd_wen;
  assign ex_if.illegal  = r_illegal;

endmodule
